// File: rtl/multi_rgb_pwm_if.sv
// Control and PWM pin bundle for the multi-channel RGB PWM engine.
// master drives the mode and colour controls; slave is the engine itself.
interface multi_rgb_pwm_if #(
   parameter int R   = 8,
   parameter int NCH = 2
);
   logic [1:0]           mode;
   logic [3*R-1:0]       static_rgb;
   logic [NCH*(R+3)-1:0] hue_offset;
   logic [NCH-1:0]       pwm_r_out;
   logic [NCH-1:0]       pwm_g_out;
   logic [NCH-1:0]       pwm_b_out;
   logic                 period_start;

   modport master (
      output mode, static_rgb, hue_offset,
      input  pwm_r_out, pwm_g_out, pwm_b_out, period_start
   );

   modport slave (
      input  mode, static_rgb, hue_offset,
      output pwm_r_out, pwm_g_out, pwm_b_out, period_start
   );
endinterface

// File: rtl/multi_rgb_pwm.sv
// NCH-channel RGB PWM engine: shared prescaler, PWM counter, gradient timer,
// hue and breathe brightness; each channel maps its hue offset to duties.
module multi_rgb_pwm_ch #(
   parameter int R = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           boundary,
   input  logic [1:0]     mode,
   input  logic [3*R-1:0] static_rgb,
   input  logic [R+2:0]   hue,
   input  logic [R+2:0]   offset,
   input  logic [R-1:0]   bv,
   input  logic [R-1:0]   cnt,
   output logic           pwm_r,
   output logic           pwm_g,
   output logic           pwm_b
);
   localparam int XW = R + 4;
   localparam logic [XW-1:0] HMOD = XW'(6 * (2**R));
   localparam logic [R-1:0]  M    = '1;

   logic [XW-1:0] off_x, sum_x;
   logic [3:0]    seg;
   logic [R-1:0]  lvl, sr, sg, sb;
   logic [R-1:0]  wr, wg, wb;
   logic [R-1:0]  dr, dg, db;
   logic [R-1:0]  lat_r, lat_g, lat_b;

   function automatic logic [R-1:0] scale(input logic [R-1:0] a, input logic [R-1:0] b);
      logic [2*R-1:0] p;
      p = {{R{1'b0}}, a} * {{R{1'b0}}, b};
      return R'(p >> R);
   endfunction

   assign {sr, sg, sb} = static_rgb;

   // Offset is at most one wheel length too large, and so is H + offset.
   always_comb begin
      off_x = {1'b0, offset};
      if (off_x >= HMOD) off_x = off_x - HMOD;
      sum_x = {1'b0, hue} + off_x;
      if (sum_x >= HMOD) sum_x = sum_x - HMOD;
   end

   assign seg = sum_x[XW-1:R];
   assign lvl = sum_x[R-1:0];

   always_comb begin
      wr = M;
      wg = '0;
      wb = M - lvl;
      case (seg)
         4'd0: begin wr = M;       wg = lvl;     wb = '0;  end
         4'd1: begin wr = M - lvl; wg = M;       wb = '0;  end
         4'd2: begin wr = '0;      wg = M;       wb = lvl; end
         4'd3: begin wr = '0;      wg = M - lvl; wb = M;   end
         4'd4: begin wr = lvl;     wg = '0;      wb = M;   end
         default: ;
      endcase
   end

   always_comb begin
      dr = '0;
      dg = '0;
      db = '0;
      case (mode)
         2'd1: begin dr = sr; dg = sg; db = sb; end
         2'd2: begin dr = wr; dg = wg; db = wb; end
         2'd3: begin dr = scale(sr, bv); dg = scale(sg, bv); db = scale(sb, bv); end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_r <= '0;
         lat_g <= '0;
         lat_b <= '0;
         pwm_r <= 1'b0;
         pwm_g <= 1'b0;
         pwm_b <= 1'b0;
      end else begin
         if (boundary) begin
            lat_r <= dr;
            lat_g <= dg;
            lat_b <= db;
         end
         pwm_r <= (cnt < lat_r);
         pwm_g <= (cnt < lat_g);
         pwm_b <= (cnt < lat_b);
      end
   end
endmodule

module multi_rgb_pwm #(
   parameter int R           = 8,
   parameter int NCH         = 2,
   parameter int DVSR        = 488,
   parameter int GRAD_THRESH = 1_000_000
) (
   input logic           clk,
   input logic           rst,
   multi_rgb_pwm_if.slave bus
);
   localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int GW = (GRAD_THRESH > 1) ? $clog2(GRAD_THRESH) : 1;
   localparam int HW = R + 3;
   localparam logic [PW-1:0] PRE_LAST  = PW'(DVSR - 1);
   localparam logic [GW-1:0] GRAD_LAST = GW'(GRAD_THRESH - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(6 * (2**R) - 1);
   localparam logic [R-1:0]  M         = '1;
   localparam logic [R-1:0]  BV_TOP_M1 = R'(2**R - 2);
   localparam logic [R-1:0]  BV_ONE    = R'(1);
   localparam logic [1:0]    MODE_RAINBOW = 2'd2;
   localparam logic [1:0]    MODE_BREATHE = 2'd3;

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   logic [PW-1:0]  pre_q;
   logic [GW-1:0]  grad_q;
   logic [R-1:0]   cnt_q;
   logic [HW-1:0]  hue_q;
   logic [R-1:0]   bv_q, bv_d;
   dir_e           dir_q, dir_d;
   logic           tick, step, boundary, ps_q;
   logic [NCH-1:0] pr, pg, pb;

   assign tick     = (pre_q == PRE_LAST);
   assign step     = (grad_q == GRAD_LAST);
   assign boundary = tick && (cnt_q == M);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q  <= '0;
         grad_q <= '0;
         cnt_q  <= '0;
         hue_q  <= '0;
         ps_q   <= 1'b0;
      end else begin
         pre_q  <= tick ? '0 : pre_q + 1'b1;
         grad_q <= step ? '0 : grad_q + 1'b1;
         if (tick) cnt_q <= cnt_q + 1'b1;
         if (step && bus.mode == MODE_RAINBOW)
            hue_q <= (hue_q == H_LAST) ? '0 : hue_q + 1'b1;
         ps_q   <= boundary;
      end
   end

   // Breathe triangle; any other mode parks it at 0 heading up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bv_q  <= '0;
         dir_q <= DIR_UP;
      end else begin
         bv_q  <= bv_d;
         dir_q <= dir_d;
      end
   end

   always_comb begin
      bv_d  = bv_q;
      dir_d = dir_q;
      if (bus.mode != MODE_BREATHE) begin
         bv_d  = '0;
         dir_d = DIR_UP;
      end else if (step) begin
         case (dir_q)
            DIR_UP: begin
               bv_d = bv_q + 1'b1;
               if (bv_q == BV_TOP_M1) dir_d = DIR_DOWN;
            end
            DIR_DOWN: begin
               bv_d = bv_q - 1'b1;
               if (bv_q == BV_ONE) dir_d = DIR_UP;
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      multi_rgb_pwm_ch #(.R(R)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .boundary   (boundary),
         .mode       (bus.mode),
         .static_rgb (bus.static_rgb),
         .hue        (hue_q),
         .offset     (bus.hue_offset[gi*HW +: HW]),
         .bv         (bv_q),
         .cnt        (cnt_q),
         .pwm_r      (pr[gi]),
         .pwm_g      (pg[gi]),
         .pwm_b      (pb[gi])
      );
   end

   assign bus.pwm_r_out    = pr;
   assign bus.pwm_g_out    = pg;
   assign bus.pwm_b_out    = pb;
   assign bus.period_start = ps_q;
endmodule

// File: tb/tb_multi_rgb_pwm.sv
// Scoreboard bench: stimulus pushes per-period high-time counts, the monitor
// integrates PWM outputs between period_start pulses and compares.
module tb_multi_rgb_pwm;
   localparam int R = 4, NCH = 2, DVSR = 2, GT = 4;
   localparam logic [1:0] MD_OFF = 2'd0, MD_STATIC = 2'd1, MD_RAINBOW = 2'd2, MD_BREATHE = 2'd3;

   typedef logic [5:0][7:0] cnts_t;  // r0,g0,b0,r1,g1,b1 high clocks per period

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   multi_rgb_pwm_if #(.R(R), .NCH(NCH)) bus();

   multi_rgb_pwm #(.R(R), .NCH(NCH), .DVSR(DVSR), .GRAD_THRESH(GT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   cnts_t exp_q[$];
   int    n_chk = 0;
   int    n_fail = 0;
   logic [5:0] outs;

   assign outs = {bus.pwm_b_out[1], bus.pwm_g_out[1], bus.pwm_r_out[1],
                  bus.pwm_b_out[0], bus.pwm_g_out[0], bus.pwm_r_out[0]};

   function automatic logic [11:0] wheel(input int h);
      int seg, lvl;
      logic [3:0] r, g, b, l;
      seg = h / 16;
      lvl = h % 16;
      l = 4'(lvl);
      r = 4'd15; g = 4'd0; b = 4'd15 - l;
      case (seg)
         0: begin r = 4'd15;     g = l;         b = 4'd0;  end
         1: begin r = 4'd15 - l; g = 4'd15;     b = 4'd0;  end
         2: begin r = 4'd0;      g = 4'd15;     b = l;     end
         3: begin r = 4'd0;      g = 4'd15 - l; b = 4'd15; end
         4: begin r = l;         g = 4'd0;      b = 4'd15; end
         default: ;
      endcase
      return {r, g, b};
   endfunction

   function automatic cnts_t to_cnts(input logic [11:0] c0, input logic [11:0] c1);
      cnts_t c;
      c[0] = {3'b0, c0[11:8], 1'b0};
      c[1] = {3'b0, c0[7:4],  1'b0};
      c[2] = {3'b0, c0[3:0],  1'b0};
      c[3] = {3'b0, c1[11:8], 1'b0};
      c[4] = {3'b0, c1[7:4],  1'b0};
      c[5] = {3'b0, c1[3:0],  1'b0};
      return c;
   endfunction

   task automatic push(input logic [11:0] c0, input logic [11:0] c1);
      exp_q.push_back(to_cnts(c0, c1));
   endtask

   task automatic wait_ps();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.period_start && n < 100);
      n_chk++;
      if (!bus.period_start) begin
         n_fail++;
         $display("FAIL ps_timeout: no period_start within %0d clks", n);
      end
   endtask

   initial begin : monitor
      int acc[6];
      int len;
      bit armed;
      cnts_t e;
      armed = 1'b0;
      len = 0;
      foreach (acc[i]) acc[i] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            armed = 1'b0;
            continue;
         end
         for (int i = 0; i < 6; i++) acc[i] += int'(outs[i]);
         len++;
         if (bus.period_start) begin
            if (armed) begin
               n_chk++;
               if (len != 32) begin
                  n_fail++;
                  $display("FAIL period_len: got %0d clks, want 32", len);
               end
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL scoreboard_empty: period ended with no expectation queued");
               end else begin
                  e = exp_q.pop_front();
                  for (int i = 0; i < 6; i++) begin
                     n_chk++;
                     if (acc[i] != int'(e[i])) begin
                        n_fail++;
                        $display("FAIL high_clks[%0d] at %0t: got %0d, want %0d", i, $time, acc[i], e[i]);
                     end
                  end
               end
            end
            armed = 1'b1;
            len = 0;
            foreach (acc[i]) acc[i] = 0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      bus.mode       = MD_OFF;
      bus.static_rgb = {4'd8, 4'd0, 4'd15};
      bus.hue_offset = {7'd32, 7'd0};
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (outs !== 6'b0 || bus.period_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: got %b/%b, want 000000/0", outs, bus.period_start);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // OFF, then STATIC entered mid-period
      wait_ps(); push(12'h000, 12'h000);
      wait_ps(); push(12'h000, 12'h000);
      repeat (10) @(negedge clk); bus.mode = MD_STATIC;
      wait_ps(); push(12'h80F, 12'h80F);
      wait_ps(); push(12'h80F, 12'h80F);
      repeat (10) @(negedge clk); bus.static_rgb = {4'd3, 4'd15, 4'd1};
      wait_ps(); push(12'h3F1, 12'h3F1);

      // RAINBOW entered just before a boundary that coincides with a step
      repeat (31) @(negedge clk); bus.mode = MD_RAINBOW;
      for (int j = 0; j <= 12; j++) begin
         wait_ps();
         push(wheel((8 * j) % 96), wheel((8 * j + 32) % 96));
      end
      repeat (10) @(negedge clk); bus.mode = MD_STATIC;
      wait_ps(); push(12'h3F1, 12'h3F1);
      // hue froze at 3: ch0 h=3, ch1 h=35
      repeat (31) @(negedge clk); bus.mode = MD_RAINBOW;
      wait_ps(); push(12'hF30, 12'h0F3);
      bus.static_rgb = 12'hFFF;

      // BREATHE: Bv 0, 8, 14 -> duty 0, 7, 13
      repeat (31) @(negedge clk); bus.mode = MD_BREATHE;
      wait_ps(); push(12'h000, 12'h000);
      wait_ps(); push(12'h777, 12'h777);
      wait_ps(); push(12'hDDD, 12'hDDD);
      wait_ps();
      repeat (5) @(negedge clk);
      n_chk++;
      if (outs !== 6'b111111) begin
         n_fail++;
         $display("FAIL breathe_high_before_rst: got %b, want 111111", outs);
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (outs !== 6'b0 || bus.period_start !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst_outs: got %b/%b, want 000000/0", outs, bus.period_start);
      end
      exp_q.delete();
      bus.mode = MD_RAINBOW;
      bus.hue_offset = {7'd104, 7'd0};
      repeat (3) @(negedge clk);
      rst = 1'b0;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.period_start && n < 100);
      n_chk++;
      if (n != 32) begin
         n_fail++;
         $display("FAIL restart_first_ps: got %0d clks, want 32", n);
      end
      // H restarted at 0: latched H=7 then 15; offset 104 reduces to 8
      push(12'hF70, 12'hFF0);
      wait_ps(); push(12'hFF0, 12'h8F0);
      wait_ps();
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
